// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and nibble validity helper
package bcd_pkg;
  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_MIN = 4'd0;

  function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - single BCD digit with load, increment/decrement and carry/borrow out
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BCD_W-1:0] rst_val,
  input  logic             inc,
  input  logic             dec,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             co,
  output logic             bo
);

  logic [BCD_W-1:0] r_q;

  // Out-of-range values fall back to a legal digit: 0 on increment, 9 on decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= rst_val;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (inc) begin
      r_q <= (r_q >= BCD_MAX) ? BCD_MIN : r_q + 4'd1;
    end else if (dec) begin
      r_q <= ((r_q == BCD_MIN) || (r_q > BCD_MAX)) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q  = r_q;
  assign co = inc & (r_q == BCD_MAX);
  assign bo = dec & (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit up/down BCD counter stepped by tick_in rising edges
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int                          NUM_DIGITS  = 4,
  parameter logic [4*NUM_DIGITS-1:0]     RESET_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        tick_in,
  input  logic                        up,
  input  logic                        load,
  input  logic [4*NUM_DIGITS-1:0]     load_val,
  output logic [4*NUM_DIGITS-1:0]     count,
  output logic                        wrap,
  output logic                        load_err
);

  logic                  r_tick_q;
  logic                  r_wrap;
  logic                  r_load_err;
  logic                  w_step;
  logic                  w_load_ok;
  logic                  w_ld;
  logic [NUM_DIGITS-1:0] w_inc;
  logic [NUM_DIGITS-1:0] w_dec;
  logic [NUM_DIGITS-1:0] w_co;
  logic [NUM_DIGITS-1:0] w_bo;

  // tick_q resets high so a tick already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tick_q <= 1'b1;
    end else begin
      r_tick_q <= tick_in;
    end
  end

  assign w_step = tick_in & ~r_tick_q & en;

  always_comb begin
    w_load_ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!is_bcd(load_val[4*i +: 4])) begin
        w_load_ok = 1'b0;
      end
    end
  end

  assign w_ld = load & w_load_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign w_inc[g] = w_step & ~load & up;
        assign w_dec[g] = w_step & ~load & ~up;
      end else begin : g_chain
        assign w_inc[g] = w_co[g-1];
        assign w_dec[g] = w_bo[g-1];
      end

      bcd_digit u_digit (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val (RESET_VALUE[4*g +: 4]),
        .inc     (w_inc[g]),
        .dec     (w_dec[g]),
        .ld      (w_ld),
        .ld_val  (load_val[4*g +: 4]),
        .q       (count[4*g +: 4]),
        .co      (w_co[g]),
        .bo      (w_bo[g])
      );
    end
  endgenerate

  // A carry/borrow out of the top digit is the wrap event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= w_co[NUM_DIGITS-1] | w_bo[NUM_DIGITS-1];
      r_load_err <= load & ~w_load_ok;
    end
  end

  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb/tb_bcd_updown_counter.sv - directed and randomized checks against a decimal reference model
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        tick_in;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        wrap;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  int m_val;
  bit m_prev;
  bit m_wrap;
  bit m_err;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(4), .RESET_VALUE(16'h0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .tick_in  (tick_in),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .load_err (load_err)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit valid_bcd(input logic [15:0] b);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance the decimal model from the current inputs, then compare.
  task automatic cyc();
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) begin
      m_val  = 0;
      m_prev = 1'b1;
    end else begin
      if (load) begin
        if (valid_bcd(load_val)) m_val = from_bcd(load_val);
        else m_err = 1'b1;
      end else if (tick_in && !m_prev && en) begin
        if (up) begin
          m_wrap = (m_val == 9999);
          m_val  = (m_val + 1) % 10000;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + 9999) % 10000;
        end
      end
      m_prev = tick_in;
    end
    @(posedge clk);
    #1;
    chk("count", count, to_bcd(m_val));
    chk("wrap", {15'd0, wrap}, {15'd0, m_wrap});
    chk("load_err", {15'd0, load_err}, {15'd0, m_err});
  endtask

  task automatic pulse();
    tick_in = 1'b0;
    cyc();
    tick_in = 1'b1;
    cyc();
  endtask

  initial begin
    m_val = 0; m_prev = 1'b1; m_wrap = 1'b0; m_err = 1'b0;
    rst_n = 1'b0; en = 1'b0; tick_in = 1'b1; up = 1'b1; load = 1'b0; load_val = '0;
    #2;

    cyc(); cyc();
    chk("reset_count", count, 16'h0000);
    rst_n = 1'b1; en = 1'b1;
    cyc();
    chk("no_step_at_release", count, 16'h0000);

    for (int i = 0; i < 12; i++) begin
      pulse();
      cyc();
    end
    chk("up12", count, 16'h0012);

    load = 1'b1; load_val = 16'h9998; cyc(); load = 1'b0;
    pulse();
    chk("to9999", count, 16'h9999);
    pulse();
    chk("wrap_up_count", count, 16'h0000);
    chk("wrap_up_pulse", {15'd0, wrap}, 16'h0001);
    cyc();
    chk("wrap_up_clear", {15'd0, wrap}, 16'h0000);

    load = 1'b1; load_val = 16'h0001; cyc(); load = 1'b0; up = 1'b0;
    pulse();
    pulse();
    chk("wrap_dn_count", count, 16'h9999);
    chk("wrap_dn_pulse", {15'd0, wrap}, 16'h0001);
    cyc();

    tick_in = 1'b0; cyc();
    tick_in = 1'b1; load = 1'b1; load_val = 16'h1234; cyc();
    chk("load_drops_step", count, 16'h1234);
    load_val = 16'h12A4; cyc(); load = 1'b0;
    chk("bad_load_hold", count, 16'h1234);
    chk("bad_load_err", {15'd0, load_err}, 16'h0001);
    cyc();
    chk("load_err_clear", {15'd0, load_err}, 16'h0000);

    en = 1'b0; up = 1'b1;
    for (int i = 0; i < 5; i++) pulse();
    chk("en_off_hold", count, 16'h1234);
    en = 1'b1; cyc(); cyc();
    chk("en_rise_no_step", count, 16'h1234);
    pulse();
    chk("en_next_edge", count, 16'h1235);

    tick_in = 1'b0; cyc();
    rst_n = 1'b0; load = 1'b1; load_val = 16'h5555; tick_in = 1'b1; cyc();
    chk("mid_reset_count", count, 16'h0000);
    chk("mid_reset_flags", {14'd0, wrap, load_err}, 16'h0000);
    rst_n = 1'b1; load = 1'b0;
    cyc();

    for (int i = 0; i < 600; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 7) != 0);
      up      = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1) load_val = to_bcd(int'($urandom_range(0, 9999)));
      else if ($urandom_range(0, 1) == 1) load_val = (i % 2 == 0) ? 16'h9999 : 16'h0000;
      else load_val = 16'($urandom);
      rst_n   = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
